// File: rtl/taqueria_pkg.sv
// -----------------------------------------------------------------------------
// taqueria_pkg
// Shared constants for the taqueria order arbiter:
//   - flavour index constants (bit position in pedido/sabor/atendido/agotado)
//   - ASCII codes emitted on the character channel for each flavour
//   - FSM state enum
//   - small helpers that map a one-hot flavour vector to its index/ASCII code
// Optional feature macro used elsewhere in this slice: TAQUERIA_STATS_EN
// -----------------------------------------------------------------------------
package taqueria_pkg;

   localparam int CHICHARON  = 0;
   localparam int PAPA       = 1;
   localparam int FRIJOL     = 2;
   localparam int DESHEBRADA = 3;

   localparam logic [7:0] ASCII_CHICHARON  = 8'd67;
   localparam logic [7:0] ASCII_PAPA       = 8'd80;
   localparam logic [7:0] ASCII_FRIJOL     = 8'd70;
   localparam logic [7:0] ASCII_DESHEBRADA = 8'd68;

   typedef enum logic {
      IDLE,
      SERVE
   } state_e;

   // One-hot flavour vector to its bit index; anything not one-hot maps to 0.
   function automatic logic [1:0] onehotToIndex(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // One-hot flavour vector to the ASCII letter the display path expects.
   function automatic logic [7:0] flavourCode(input logic [3:0] oh);
      logic [7:0] code;
      code = 8'd0;
      case (oh)
         4'b0001: code = ASCII_CHICHARON;
         4'b0010: code = ASCII_PAPA;
         4'b0100: code = ASCII_FRIJOL;
         4'b1000: code = ASCII_DESHEBRADA;
         default: code = 8'd0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/taqueria_if.sv
// -----------------------------------------------------------------------------
// taqueria_if
// Valid/ready character channel carrying the ASCII code of the flavour being
// served towards the character/display path.
//   char_out   : ASCII code of the granted flavour (0 when not valid)
//   char_valid : char_out holds an order waiting to be taken
//   char_ready : consumer accepts char_out this cycle
// Modports: master (arbiter side), slave (consumer side).
// -----------------------------------------------------------------------------
interface taqueria_if;

   logic [7:0] char_out;
   logic       char_valid;
   logic       char_ready;

   modport master (
      output char_out,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  char_out,
      input  char_valid,
      output char_ready
   );

endinterface

// File: rtl/taqueria_arbiter_sabor_rr_pick.sv
// -----------------------------------------------------------------------------
// sabor_rr_pick
// Combinational round-robin picker for the four taco flavours.
//   elig      in  4 : flavours that are both requested and in stock
//   ptr       in  2 : index of the last flavour served
//   grant     out 4 : one-hot choice, first eligible bit after ptr (with wrap)
//   any_valid out 1 : at least one flavour is eligible
// -----------------------------------------------------------------------------
module sabor_rr_pick (
   input  logic [3:0] elig,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic       any_valid
);

   logic [1:0] candidate;
   logic       found;

   // Walk the four positions starting just after the last served flavour so
   // the flavour that was served most recently has the lowest priority.
   always_comb begin
      grant     = 4'b0000;
      found     = 1'b0;
      candidate = 2'd0;
      any_valid = |elig;
      for (int i = 1; i <= 4; i++) begin
         candidate = ptr + 2'(i);
         if (!found && elig[candidate]) begin
            grant[candidate] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/taqueria_arbiter.sv
// -----------------------------------------------------------------------------
// taqueria_arbiter
// Round-robin order arbiter for the four taco flavours with per-flavour stock.
// Parameters:
//   STOCK_W    : width of each stock counter
//   STOCK_INIT : value loaded on reset and on refill (must fit in STOCK_W bits)
// Ports:
//   clk       in  1 : clock, rising edge
//   rst       in  1 : synchronous active-high reset
//   pedido    in  4 : level requests (bit0 Chicharon .. bit3 Deshebrada)
//   surtir    in  1 : refill pulse, reloads every stock counter
//   sabor     out 4 : registered one-hot grant, 0 while idle
//   atendido  out 4 : one-cycle completion pulse to the served requester
//   agotado   out 4 : sold-out flags, bit i set when stock[i] == 0
//   chr       master modport of taqueria_if (char_out/char_valid/char_ready)
//   vendidos  out 16: saturating count of completed orders (only when the
//                     TAQUERIA_STATS_EN macro is defined)
// -----------------------------------------------------------------------------
module taqueria_arbiter
   import taqueria_pkg::*;
#(
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  pedido,
   input  logic        surtir,
   output logic [3:0]  sabor,
   output logic [3:0]  atendido,
   output logic [3:0]  agotado,
   taqueria_if.master  chr
`ifdef TAQUERIA_STATS_EN
   ,
   output logic [15:0] vendidos
`endif
);

   state_e              state_q;
   logic [1:0]          ptr_q;
   logic [3:0]          sabor_q;
   logic [7:0]          char_out_q;
   logic                char_valid_q;
   logic [3:0]          atendido_q;
   logic [STOCK_W-1:0]  stock_q [4];
   logic [STOCK_W-1:0]  stock_d [4];

   logic [3:0]          elig;
   logic [3:0]          pick_grant;
   logic                pick_any;
   logic                handshake;
   logic [1:0]          grant_idx;

   // An order is only committed by the consumer taking the character.
   assign handshake = (state_q == SERVE) && chr.char_ready;
   assign grant_idx = onehotToIndex(sabor_q);

   // Sold-out flags follow the registered counters, so they move one cycle
   // after the decrement or refill that changed the count.
   always_comb begin
      agotado = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         agotado[i] = (stock_q[i] == '0);
      end
   end

   // Sold-out flavours are simply invisible to the picker, which is what
   // keeps the counters from ever being asked to go below zero.
   assign elig = pedido & ~agotado;

   sabor_rr_pick u_pick (
      .elig      (elig),
      .ptr       (ptr_q),
      .grant     (pick_grant),
      .any_valid (pick_any)
   );

   // Next stock values: a completed order takes one unit from its flavour,
   // and a refill overrides everything, including a same-cycle decrement.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stock_d[i] = stock_q[i];
      end
      if (handshake) begin
         stock_d[grant_idx] = stock_q[grant_idx] - STOCK_W'(1);
      end
      if (surtir) begin
         for (int i = 0; i < 4; i++) begin
            stock_d[i] = STOCK_W'(STOCK_INIT);
         end
      end
   end

   // Stock counters. Reset wins over everything, so an order abandoned by
   // reset never consumes stock.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            stock_q[i] <= STOCK_W'(STOCK_INIT);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            stock_q[i] <= stock_d[i];
         end
      end
   end

   // Order FSM with all channel outputs registered. In IDLE the picker's
   // choice is latched into sabor together with its ASCII code; in SERVE
   // both are frozen until the consumer takes the character, then the
   // served flavour becomes the new round-robin pointer and gets its
   // completion pulse. Dropping the request while in SERVE changes nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= 2'd3;
         sabor_q      <= 4'b0000;
         char_out_q   <= 8'd0;
         char_valid_q <= 1'b0;
         atendido_q   <= 4'b0000;
      end else begin
         atendido_q <= 4'b0000;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  sabor_q      <= pick_grant;
                  char_out_q   <= flavourCode(pick_grant);
                  char_valid_q <= 1'b1;
                  state_q      <= SERVE;
               end
            end
            SERVE: begin
               if (chr.char_ready) begin
                  ptr_q        <= grant_idx;
                  atendido_q   <= sabor_q;
                  sabor_q      <= 4'b0000;
                  char_out_q   <= 8'd0;
                  char_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sabor          = sabor_q;
   assign atendido       = atendido_q;
   assign chr.char_out   = char_out_q;
   assign chr.char_valid = char_valid_q;

`ifdef TAQUERIA_STATS_EN
   logic [15:0] vendidos_q;

   // Lifetime order count; refills do not touch it and it sticks at its
   // maximum instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         vendidos_q <= 16'd0;
      end else if (handshake && (vendidos_q != 16'hFFFF)) begin
         vendidos_q <= vendidos_q + 16'd1;
      end
   end

   assign vendidos = vendidos_q;
`endif

endmodule

// File: tb/tb_taqueria_arbiter.sv
// -----------------------------------------------------------------------------
// tb_taqueria_arbiter
// Testbench for taqueria_arbiter: a directed vector table, hand-written
// sequences for the multi-cycle corner cases, and a randomized phase checked
// against a behavioural model of the order/stock rules.
// -----------------------------------------------------------------------------
module tb_taqueria_arbiter;

   localparam int INIT = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        surtir;
   logic [3:0]  pedido;
   logic [3:0]  sabor;
   logic [3:0]  atendido;
   logic [3:0]  agotado;
`ifdef TAQUERIA_STATS_EN
   logic [15:0] vendidos;
`endif

   taqueria_if chrIf();

   taqueria_arbiter #(
      .STOCK_W    (4),
      .STOCK_INIT (INIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pedido   (pedido),
      .surtir   (surtir),
      .sabor    (sabor),
      .atendido (atendido),
      .agotado  (agotado),
      .chr      (chrIf)
`ifdef TAQUERIA_STATS_EN
      ,
      .vendidos (vendidos)
`endif
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: which flavour (if any) is being served, how much of
   // each flavour is left, who was served last, and the pending pulse.
   bit         mBusy;
   int         mFlavour;
   int         mLast;
   int         mStock [4];
   logic [3:0] mPulse;
   int         mSold;
   int         asciiOf [4];

   typedef struct {
      logic [3:0] pedido;
      logic       ready;
      logic [3:0] expSabor;
      logic       expValid;
      logic [7:0] expChar;
      logic [3:0] expAtendido;
   } vec_t;

   vec_t vecs [11];

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // First requested in-stock flavour after the last served one, wrapping.
   function automatic int nextFlavour(input logic [3:0] req);
      for (int step = 1; step <= 4; step++) begin
         int k;
         k = (mLast + step) % 4;
         if (req[k] && mStock[k] > 0) return k;
      end
      return -1;
   endfunction

   task automatic modelStep(input logic [3:0] p, input logic s, input logic r, input logic rs);
      int pick;
      if (rs) begin
         mBusy  = 1'b0;
         mLast  = 3;
         mPulse = 4'b0000;
         mSold  = 0;
         for (int i = 0; i < 4; i++) mStock[i] = INIT;
         return;
      end
      mPulse = 4'b0000;
      if (!mBusy) begin
         pick = nextFlavour(p);
         if (pick >= 0) begin
            mBusy    = 1'b1;
            mFlavour = pick;
         end
      end else if (r) begin
         mBusy  = 1'b0;
         mLast  = mFlavour;
         mPulse = 4'(1 << mFlavour);
         if (mStock[mFlavour] > 0) mStock[mFlavour] = mStock[mFlavour] - 1;
         if (mSold < 65535) mSold = mSold + 1;
      end
      if (s) begin
         for (int i = 0; i < 4; i++) mStock[i] = INIT;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] p, input logic s, input logic r, input logic rs);
      pedido            = p;
      surtir            = s;
      chrIf.char_ready  = r;
      rst               = rs;
      modelStep(p, s, r, rs);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [3:0] expAgotado;
      expAgotado = 4'b0000;
      for (int i = 0; i < 4; i++) expAgotado[i] = (mStock[i] == 0);
      checkEq({tag, ".sabor"},      32'(sabor),            mBusy ? 32'(1 << mFlavour) : 32'd0);
      checkEq({tag, ".char_valid"}, 32'(chrIf.char_valid), 32'(mBusy));
      checkEq({tag, ".char_out"},   32'(chrIf.char_out),   mBusy ? 32'(asciiOf[mFlavour]) : 32'd0);
      checkEq({tag, ".atendido"},   32'(atendido),         32'(mPulse));
      checkEq({tag, ".agotado"},    32'(agotado),          32'(expAgotado));
`ifdef TAQUERIA_STATS_EN
      checkEq({tag, ".vendidos"},   32'(vendidos),         32'(mSold));
`endif
   endtask

   task automatic doReset();
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      checkOutput("reset");
   endtask

   initial begin
      int served;
      asciiOf = '{67, 80, 70, 68};

      // Directed vectors starting from reset (ptr=3, all stock 10).
      vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'd67, 4'b0000};
      vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0,  4'b0001};
      vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0,  4'b0000};
      vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'd80, 4'b0000};
      vecs[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'd0,  4'b0010};
      vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'd70, 4'b0000};
      vecs[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'd0,  4'b0100};
      vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'd68, 4'b0000};
      vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'd0,  4'b1000};
      vecs[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'd67, 4'b0000};
      vecs[10] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'd0,  4'b0001};

      pedido           = 4'b0000;
      surtir           = 1'b0;
      rst              = 1'b1;
      chrIf.char_ready = 1'b0;

      doReset();
      checkEq("reset.agotado0", 32'(agotado), 32'd0);

      for (int v = 0; v < 11; v++) begin
         applyStimulus(vecs[v].pedido, 1'b0, vecs[v].ready, 1'b0);
         checkEq($sformatf("vec%0d.sabor", v),    32'(sabor),            32'(vecs[v].expSabor));
         checkEq($sformatf("vec%0d.valid", v),    32'(chrIf.char_valid), 32'(vecs[v].expValid));
         checkEq($sformatf("vec%0d.char", v),     32'(chrIf.char_out),   32'(vecs[v].expChar));
         checkEq($sformatf("vec%0d.atendido", v), 32'(atendido),         32'(vecs[v].expAtendido));
      end

      // Stalled Frijol order: request dropped mid-wait, order still completes.
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus((i < 2) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0);
         checkEq("stall.valid", 32'(chrIf.char_valid), 32'd1);
         checkEq("stall.char",  32'(chrIf.char_out),   32'd70);
         checkEq("stall.sabor", 32'(sabor),            32'd4);
      end
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkEq("stall.atendido", 32'(atendido), 32'd4);
      checkOutput("stall");

      // Drain Papa until sold out, confirm idling, then refill.
      doReset();
      served = 0;
      for (int i = 0; i < 40 && !agotado[1]; i++) begin
         applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
         checkOutput("drainPapa");
         if (atendido[1]) served++;
      end
      checkEq("drainPapa.orders",  32'(served),  32'(INIT));
      checkEq("drainPapa.agotado", 32'(agotado), 32'd2);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
         checkEq("soldOut.valid", 32'(chrIf.char_valid), 32'd0);
      end
      applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
      checkEq("refill.agotado", 32'(agotado), 32'd0);
      applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
      checkEq("refill.resume", 32'(sabor), 32'd2);
      checkOutput("refill");

      // Refill on the same edge as a Frijol handshake: refill must win, so a
      // full INIT orders are available afterwards.
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
      checkEq("refillRace.atendido", 32'(atendido), 32'd4);
      served = 0;
      for (int i = 0; i < 40 && !agotado[2]; i++) begin
         applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
         checkOutput("refillRace");
         if (atendido[2]) served++;
      end
      checkEq("refillRace.orders", 32'(served), 32'(INIT));

      // Reset while an order is waiting: dropped with no pulse.
      doReset();
      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
      checkEq("rstServe.valid",    32'(chrIf.char_valid), 32'd0);
      checkEq("rstServe.sabor",    32'(sabor),            32'd0);
      checkEq("rstServe.atendido", 32'(atendido),         32'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkEq("rstServe.noPulse",  32'(atendido),         32'd0);
      checkEq("rstServe.agotado",  32'(agotado),          32'd0);

`ifdef TAQUERIA_STATS_EN
      // Three orders, then a refill: the sales count must hold at 3.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      checkEq("stats.vendidos", 32'(vendidos), 32'd3);
`endif

      // Randomized traffic against the model.
      doReset();
      for (int i = 0; i < 600; i++) begin
         applyStimulus(4'($urandom_range(0, 15)),
                       ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 149) == 0));
         checkOutput("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
